// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter with a per-winner hold limit.
// Outputs are registered: a decision taken at a clock edge is visible right after it.
module rr_arbiter8 #(
  parameter int MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] req,
  output logic       gnt_en,
  output logic [2:0] gnt_idx,
  output logic [7:0] gnt
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [3:0] MAX_CNT = 4'(MAX_HOLD);

  state_t     state_r, state_s;
  logic [2:0] ptr_r, ptr_s;
  logic [3:0] cnt_r, cnt_s;
  logic [2:0] idx_s;
  logic       en_s;
  logic [7:0] gnt_s;
  logic [2:0] rel_ptr_s;
  logic [2:0] win_idle_s;
  logic [2:0] win_rel_s;

  // First set bit of r scanning upward from p, wrapping modulo 8.
  function automatic logic [2:0] pick(input logic [7:0] r, input logic [2:0] p);
    logic [2:0] idx;
    logic       found;
    pick  = p;
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      idx = p + 3'(i);
      if (!found && r[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  endfunction

  // Candidate winners: from the stored pointer, and from the post-release pointer.
  always_comb begin
    rel_ptr_s  = gnt_idx + 3'd1;
    win_idle_s = pick(req, ptr_r);
    win_rel_s  = pick(req, rel_ptr_s);
  end

  // Next-state and next-output decision.
  always_comb begin
    state_s = state_r;
    ptr_s   = ptr_r;
    cnt_s   = cnt_r;
    idx_s   = gnt_idx;
    en_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (en && (req != 8'h00)) begin
          state_s = GRANT;
          idx_s   = win_idle_s;
          cnt_s   = 4'd1;
          en_s    = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      GRANT: begin
        if (!en) begin
          state_s = IDLE;
          ptr_s   = rel_ptr_s;
          cnt_s   = 4'd0;
        end else if (req[gnt_idx] && (cnt_r < MAX_CNT)) begin
          cnt_s = cnt_r + 4'd1;
          en_s  = 1'b1;
        end else begin
          // Release: the old winner drops to lowest priority for the re-pick.
          ptr_s = rel_ptr_s;
          if (req != 8'h00) begin
            idx_s = win_rel_s;
            cnt_s = 4'd1;
            en_s  = 1'b1;
          end else begin
            state_s = IDLE;
            cnt_s   = 4'd0;
          end
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = 4'd0;
      end
    endcase
    gnt_s = en_s ? (8'h01 << idx_s) : 8'h00;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      ptr_r   <= 3'd0;
      cnt_r   <= 4'd0;
      gnt_en  <= 1'b0;
      gnt_idx <= 3'd0;
      gnt     <= 8'h00;
    end else begin
      state_r <= state_s;
      ptr_r   <= ptr_s;
      cnt_r   <= cnt_s;
      gnt_en  <= en_s;
      gnt_idx <= idx_s;
      gnt     <= gnt_s;
    end
  end

endmodule

// File: tb/tb_rr_arbiter8.sv
// Scoreboard bench for rr_arbiter8: the driver queues hand-computed expectations,
// a monitor pops and compares one per cycle after each rising edge.
module tb_rr_arbiter8;

  logic       clk;
  logic       rst;
  logic       en;
  logic [7:0] req;
  logic       gnt_en;
  logic [2:0] gnt_idx;
  logic [7:0] gnt;

  int tests;
  int fails;
  bit done;

  typedef struct {
    string      name;
    logic       exp_en;
    logic [2:0] exp_idx;
    bit         chk_idx;
  } exp_t;

  exp_t sb_q[$];

  rr_arbiter8 #(.MAX_HOLD(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .req    (req),
    .gnt_en (gnt_en),
    .gnt_idx(gnt_idx),
    .gnt    (gnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs and queue what must appear after the next edge.
  task automatic step(input logic r, input logic e, input logic [7:0] q,
                      input logic xe, input logic [2:0] xi, input bit ci,
                      input string nm);
    exp_t x;
    @(negedge clk);
    rst = r;
    en  = e;
    req = q;
    x.name    = nm;
    x.exp_en  = xe;
    x.exp_idx = xi;
    x.chk_idx = ci;
    sb_q.push_back(x);
  endtask

  // Monitor: invariants every cycle, scoreboard compare when an entry is queued.
  initial begin
    exp_t       x;
    logic [7:0] exp_gnt;
    logic [7:0] dec;
    while (!done) begin
      @(posedge clk);
      #1;
      dec = gnt_en ? (8'h01 << gnt_idx) : 8'h00;
      tests++;
      if (gnt !== dec || $countones(gnt) > 1) begin
        fails++;
        $display("FAIL invariant t=%0t: gnt=%h gnt_en=%b gnt_idx=%0d, required gnt=%h one-hot",
                 $time, gnt, gnt_en, gnt_idx, dec);
      end
      if (sb_q.size() > 0) begin
        x = sb_q.pop_front();
        exp_gnt = x.exp_en ? (8'h01 << x.exp_idx) : 8'h00;
        tests++;
        if (gnt_en !== x.exp_en || gnt !== exp_gnt ||
            (x.chk_idx && gnt_idx !== x.exp_idx)) begin
          fails++;
          $display("FAIL %s t=%0t: got gnt_en=%b gnt_idx=%0d gnt=%h, required gnt_en=%b gnt_idx=%0d gnt=%h",
                   x.name, $time, gnt_en, gnt_idx, gnt, x.exp_en, x.exp_idx, exp_gnt);
        end
      end
    end
  end

  initial begin
    tests = 0;
    fails = 0;
    done  = 1'b0;
    rst   = 1'b1;
    en    = 1'b0;
    req   = 8'h00;

    // Reset state, then sole requester 3: four held cycles, then re-granted with no gap.
    step(1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 1'b1, "reset");
    step(1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 1'b1, "reset_hold");
    for (int k = 0; k < 8; k++)
      step(1'b0, 1'b1, 8'h08, 1'b1, 3'd3, 1'b1, "sole_req3");

    // All requesting: 0..7 then 0, four cycles each.
    step(1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 1'b1, "reset_s2");
    for (int g = 0; g < 9; g++)
      for (int k = 0; k < 4; k++)
        step(1'b0, 1'b1, 8'hFF, 1'b1, 3'(g % 8), 1'b1, "rr_all");

    // Early release by requester 0, then 7, then back to 0.
    step(1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 1'b1, "reset_s3");
    step(1'b0, 1'b1, 8'h81, 1'b1, 3'd0, 1'b1, "drop_g0_c1");
    step(1'b0, 1'b1, 8'h81, 1'b1, 3'd0, 1'b1, "drop_g0_c2");
    step(1'b0, 1'b1, 8'h80, 1'b1, 3'd7, 1'b1, "drop_to7");
    step(1'b0, 1'b1, 8'h80, 1'b1, 3'd7, 1'b1, "hold7");
    step(1'b0, 1'b1, 8'h01, 1'b1, 3'd0, 1'b1, "rel7_to0");
    step(1'b0, 1'b1, 8'h00, 1'b0, 3'd0, 1'b1, "rel0_idle");

    // Enable gating.
    step(1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 1'b1, "reset_s4");
    step(1'b0, 1'b0, 8'hFF, 1'b0, 3'd0, 1'b1, "en0_block");
    step(1'b0, 1'b0, 8'hFF, 1'b0, 3'd0, 1'b1, "en0_block2");
    step(1'b0, 1'b1, 8'hFF, 1'b1, 3'd0, 1'b1, "en1_grant0");
    step(1'b0, 1'b1, 8'hFF, 1'b1, 3'd0, 1'b1, "en1_hold0");
    step(1'b0, 1'b0, 8'hFF, 1'b0, 3'd0, 1'b1, "en0_midgrant");
    step(1'b0, 1'b1, 8'hFF, 1'b1, 3'd1, 1'b1, "en1_next1");

    // Reset mid-grant, then first pick starts from pointer 0.
    step(1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 1'b1, "reset_s5");
    step(1'b0, 1'b1, 8'h20, 1'b1, 3'd5, 1'b1, "grant5");
    step(1'b0, 1'b1, 8'h20, 1'b1, 3'd5, 1'b1, "hold5");
    step(1'b1, 1'b1, 8'h20, 1'b0, 3'd0, 1'b1, "rst_midgrant");
    step(1'b0, 1'b1, 8'h24, 1'b1, 3'd2, 1'b1, "post_rst_2");
    step(1'b0, 1'b1, 8'h24, 1'b1, 3'd2, 1'b1, "post_rst_hold2");

    @(posedge clk);
    #2;
    tests++;
    if (sb_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb_q.size());
    end
    done = 1'b1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rr_arbiter8.md
RR_ARBITER8 -- requirements
Module: rr_arbiter8

Interface
REQ-001 The block SHALL have one clock, clk, and a synchronous, active-high reset, rst; all state SHALL change only on the rising edge of clk.
REQ-002 Parameter MAX_HOLD, default 4, SHALL set the maximum consecutive grant cycles per winner; legal range is 1..15.
REQ-003 Port clk, input, 1 bit: clock, rising edge.
REQ-004 Port rst, input, 1 bit: synchronous active-high reset.
REQ-005 Port en, input, 1 bit: arbitration enable; 0 blocks new grants and terminates any current grant.
REQ-006 Port req, input, 8 bits: request vector; bit i is requester i.
REQ-007 Port gnt_en, output, 1 bit: a grant is active.
REQ-008 Port gnt_idx, output, 3 bits: index of the granted requester, valid only while gnt_en=1.
REQ-009 Port gnt, output, 8 bits: one-hot grant, equal to the 3-to-8 decode of gnt_idx when gnt_en=1, and all zero otherwise.

Function
REQ-010 All outputs SHALL be registered; a decision made at edge N SHALL be visible after edge N, giving 1-cycle latency from req to gnt.
REQ-011 The FSM SHALL have two states, IDLE and GRANT, plus an internal 3-bit priority pointer ptr and a 4-bit hold counter cnt.
REQ-012 In IDLE with en=1 and req!=0, the winner SHALL be the first set bit of req scanning ptr, ptr+1, ... modulo 8; next state SHALL be GRANT with gnt_idx=winner and cnt=1.
REQ-013 In IDLE with en=0 or req=0, the FSM SHALL stay in IDLE with gnt_en=0, gnt=0, and gnt_idx holding its last value.
REQ-014 In GRANT, when en=1, req[gnt_idx]=1 and cnt<MAX_HOLD, the grant SHALL be held and cnt SHALL increment by 1.
REQ-015 In GRANT, a release edge is one where req[gnt_idx]=0 or cnt=MAX_HOLD; on it, ptr SHALL become gnt_idx+1 modulo 8 (7 wraps to 0).
REQ-016 On a release edge with en=1, the new winner SHALL be chosen per REQ-012 from the updated ptr, in the same edge; gnt_en SHALL stay 1, with no idle gap between back-to-back grants.
REQ-017 On a release edge with no requester set, the FSM SHALL go to IDLE.
REQ-018 When the previous winner is still requesting after a MAX_HOLD release, it has lowest priority; if it is the only requester, it SHALL be re-granted with cnt=1.
REQ-019 In GRANT with en=0, the FSM SHALL go to IDLE, clear gnt_en and gnt, and set ptr=gnt_idx+1 modulo 8.
REQ-020 gnt SHALL never have more than one bit set, and gnt_en SHALL equal the OR of gnt in every cycle.
REQ-021 Changes to req bits other than the current winner SHALL NOT affect an ongoing grant.

Reset
REQ-022 When rst=1 at a clock edge, the block SHALL set state=IDLE, gnt_en=0, gnt=8'h00, gnt_idx=0, ptr=0 and cnt=0, regardless of the current state.
REQ-023 rst SHALL take priority over en and req; a reset applied mid-grant SHALL drop gnt on the following cycle with no release-side ptr update.
REQ-024 After reset deasserts, the first arbitration SHALL start from ptr=0.

Verification
REQ-025 The bench SHALL check: reset, then en=1, req=8'h08 held -> from the 1st cycle after the edge, gnt=8'h08 and gnt_idx=3 for 4 cycles; then re-granted gnt=8'h08 with no gap (sole requester, REQ-018).
REQ-026 The bench SHALL check: req=8'hFF held, en=1, MAX_HOLD=4 -> grants to 0,1,2,...,7,0 in order, each lasting exactly 4 cycles, with no idle cycle between grants (wrap 7->0).
REQ-027 The bench SHALL check: req=8'h81, with req[0] dropped after 2 granted cycles -> gnt=8'h01 for 2 cycles, then gnt=8'h80 on the next cycle; after 8'h80 releases with req=8'h01, the next grant is index 0.
REQ-028 The bench SHALL check: en=0 with req=8'hFF -> gnt stays 8'h00; then en=1 -> gnt=8'h01 one cycle later; then en=0 mid-grant -> gnt=8'h00 on the next cycle, and the next grant after en=1 is index 1.
REQ-029 The bench SHALL check: rst=1 while gnt=8'h20 -> gnt=8'h00 and gnt_idx=0 the next cycle; with req=8'h24 after reset, the first grant is index 2.
REQ-030 For every scenario, the bench SHALL check gnt == (gnt_en ? 1<<gnt_idx : 0) and that gnt is one-hot every cycle.
